// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU issue sequencer:
//   - R-type funct field encodings accepted by the sequencer
//   - 4-bit ALU control codes driven to the registered ALU
//   - issue FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // R-type funct encodings
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_funct_dec.sv
// ----------------------------------------------------------------------------
// alu_funct_dec
// Combinational decode of the R-type funct field to the ALU control code.
// Ports:
//   funct      in  6  R-type funct field
//   control    out 4  ALU control code (don't-care when illegal)
//   illegal    out 1  funct is not one of the supported operations
//   is_addsub  out 1  operation is ADD or SUB (overflow is meaningful)
// ----------------------------------------------------------------------------
module alu_funct_dec
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] control,
    output logic       illegal,
    output logic       is_addsub
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        control   = ALUC_AND;
        illegal   = 1'b0;
        is_addsub = 1'b0;
        case (funct)
            FUNCT_AND: control = ALUC_AND;
            FUNCT_OR:  control = ALUC_OR;
            FUNCT_ADD: begin
                control   = ALUC_ADD;
                is_addsub = 1'b1;
            end
            FUNCT_SUB: begin
                control   = ALUC_SUB;
                is_addsub = 1'b1;
            end
            FUNCT_SLT: control = ALUC_SLT;
            FUNCT_NOR: control = ALUC_NOR;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue sequencer in front of a registered 32-bit ALU. Accepts one R-type op
// over valid/ready, drives registered operands/control to the ALU, waits
// ALU_LAT cycles, captures result and flags, and offers a writeback packet
// under valid/ready back-pressure. Writeback is suppressed on ADD/SUB signed
// overflow, on rd==0 and on an illegal funct (which bypasses the ALU).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               upstream handshake
//   in_funct, in_rs_data,
//   in_rt_data, in_rd               op fields
//   alu_src1/alu_src2/alu_control   registered ALU inputs
//   alu_result/zero/cout/overflow   ALU outputs
//   out_valid/out_ready             downstream handshake
//   out_result, out_rd, out_wen,
//   out_zero, out_cout,
//   out_ovf_exc, out_illegal        writeback packet
// ----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,   // 1..7
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [4:0]        in_rd,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_zero,
    output logic              out_cout,
    output logic              out_ovf_exc,
    output logic              out_illegal
);

    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t     state, state_next;
    logic [2:0] cnt;
    logic [4:0] rd_q;
    logic       is_addsub_q;

    logic [3:0] dec_control;
    logic       dec_illegal;
    logic       dec_is_addsub;

    logic       accept;
    logic       capture;
    logic       pop;
    logic       ovf_exc;

    alu_funct_dec u_dec (
        .funct     (in_funct),
        .control   (dec_control),
        .illegal   (dec_illegal),
        .is_addsub (dec_is_addsub)
    );

    assign in_ready = (state == IDLE);
    assign ovf_exc  = alu_overflow & is_addsub_q;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = dec_illegal ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0) state_next = CAPT;
            end
            CAPT: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            rd_q        <= 5'd0;
            is_addsub_q <= 1'b0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_control <= 4'd0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= 5'd0;
            out_wen     <= 1'b0;
            out_zero    <= 1'b0;
            out_cout    <= 1'b0;
            out_ovf_exc <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_next;

            if (accept && !dec_illegal) begin
                alu_src1    <= in_rs_data;
                alu_src2    <= in_rt_data;
                alu_control <= dec_control;
                rd_q        <= in_rd;
                is_addsub_q <= dec_is_addsub;
                cnt         <= CNT_INIT;
            end else if (state == EXEC && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end

            // Illegal ops never reach the ALU: the packet is built directly.
            if (accept && dec_illegal) begin
                out_valid   <= 1'b1;
                out_result  <= '0;
                out_rd      <= in_rd;
                out_wen     <= 1'b0;
                out_zero    <= 1'b0;
                out_cout    <= 1'b0;
                out_ovf_exc <= 1'b0;
                out_illegal <= 1'b1;
            end else if (capture) begin
                out_valid   <= 1'b1;
                out_result  <= alu_result;
                out_rd      <= rd_q;
                out_wen     <= (rd_q != 5'd0) & ~ovf_exc;
                out_zero    <= alu_zero;
                out_cout    <= alu_cout;
                out_ovf_exc <= ovf_exc;
                out_illegal <= 1'b0;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
